// File: rtl/vospi_frame_ctrl.sv
// vospi_frame_ctrl: captures one VoSPI frame (or free-runs) into a byte-addressed frame buffer.
// Optional watchdog/ABORT path is built only when VOSPI_FRAME_CTRL_TIMEOUT_EN is defined.
module vospi_frame_ctrl #(
    parameter int line_bytes_p     = 160,
    parameter int frame_packets_p  = 60,
    parameter int timeout_cycles_p = 1000000,
    localparam int frame_bytes_lp  = line_bytes_p * frame_packets_p,
    localparam int aw_lp           = $clog2(frame_bytes_lp),
    localparam int lw_lp           = $clog2(frame_packets_p)
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             capture_i,
    input  logic             continuous_i,
    output logic             vospi_start_o,
    input  logic             vospi_valid_i,
    input  logic [7:0]       vospi_data_i,
    output logic             wr_en_o,
    output logic [aw_lp-1:0] wr_addr_o,
    output logic [7:0]       wr_data_o,
    output logic [lw_lp-1:0] line_o,
    output logic             frame_done_o,
    output logic             busy_o,
    output logic             timeout_o,
    output logic [15:0]      frame_count_o
);
    localparam int cw_lp = line_bytes_p > 1 ? $clog2(line_bytes_p) : 1;

    typedef enum logic [1:0] {IDLE, START, CAPTURE, ABORT} state_t;

    state_t             state_q, state_d;
    logic [aw_lp-1:0]   byte_cnt;
    logic [cw_lp-1:0]   col_cnt;
    logic [lw_lp-1:0]   line_cnt;
    logic               accept, last, launch;

    assign launch = state_q == IDLE && capture_i;
    assign accept = state_q == CAPTURE && vospi_valid_i;
    assign last   = accept && byte_cnt == aw_lp'(frame_bytes_lp - 1);

`ifdef VOSPI_FRAME_CTRL_TIMEOUT_EN
    localparam int tw_lp = $clog2(timeout_cycles_p + 1);
    logic [tw_lp-1:0] wd_cnt;
    logic             expire;
    // a byte arriving on the expiry cycle takes priority over the abort
    assign expire = state_q == CAPTURE && !vospi_valid_i && wd_cnt == tw_lp'(timeout_cycles_p - 1);
`else
    // watchdog compiled out; the parameter only keeps the interface stable
    assign timeout_o = timeout_cycles_p < 0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = capture_i ? START : IDLE;
            START:   state_d = CAPTURE;
            CAPTURE: begin
                if (last) state_d = continuous_i ? CAPTURE : IDLE;
`ifdef VOSPI_FRAME_CTRL_TIMEOUT_EN
                else if (expire) state_d = ABORT;
`endif
            end
            ABORT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q       <= IDLE;
            byte_cnt      <= '0;
            col_cnt       <= '0;
            line_cnt      <= '0;
            vospi_start_o <= 1'b0;
            wr_en_o       <= 1'b0;
            wr_addr_o     <= '0;
            wr_data_o     <= '0;
            line_o        <= '0;
            frame_done_o  <= 1'b0;
            busy_o        <= 1'b0;
            frame_count_o <= '0;
        end else begin
            state_q       <= state_d;
            vospi_start_o <= state_d == START;
            busy_o        <= state_d != IDLE;
            wr_en_o       <= accept;
            frame_done_o  <= last;
            if (launch) begin
                byte_cnt <= '0;
                col_cnt  <= '0;
                line_cnt <= '0;
                line_o   <= '0;
            end else if (accept) begin
                wr_addr_o <= byte_cnt;
                wr_data_o <= vospi_data_i;
                line_o    <= line_cnt;
                if (last) begin
                    byte_cnt      <= '0;
                    col_cnt       <= '0;
                    line_cnt      <= '0;
                    frame_count_o <= frame_count_o + 16'd1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                    col_cnt  <= col_cnt == cw_lp'(line_bytes_p - 1) ? '0 : col_cnt + 1'b1;
                    line_cnt <= col_cnt == cw_lp'(line_bytes_p - 1) ? line_cnt + 1'b1 : line_cnt;
                end
            end
        end
    end

`ifdef VOSPI_FRAME_CTRL_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wd_cnt    <= '0;
            timeout_o <= 1'b0;
        end else begin
            if (launch || state_q == START || accept) wd_cnt <= '0;
            else if (state_q == CAPTURE) wd_cnt <= wd_cnt + 1'b1;
            if (state_d == ABORT) timeout_o <= 1'b1;
            else if (launch) timeout_o <= 1'b0;
        end
    end
`endif
endmodule

// File: tb/tb_vospi_frame_ctrl.sv
// tb_vospi_frame_ctrl: table-driven single-frame check plus hand sequences for
// continuous mode, async reset, ignored capture requests and the watchdog.
module tb_vospi_frame_ctrl;
    logic        clk = 1'b0, reset_ni = 1'b0;
    logic        capture_i = 1'b0, continuous_i = 1'b0, vospi_valid_i = 1'b0;
    logic [7:0]  vospi_data_i = 8'h00;
    logic        vospi_start_o, wr_en_o, frame_done_o, busy_o, timeout_o;
    logic [3:0]  wr_addr_o;
    logic [7:0]  wr_data_o;
    logic [1:0]  line_o;
    logic [15:0] frame_count_o;

    int checks = 0, failures = 0, starts = 0, dones = 0;
    int s0, d0;
    bit busy_ok;

    vospi_frame_ctrl #(.line_bytes_p(4), .frame_packets_p(3), .timeout_cycles_p(20)) dut (
        .clk_i(clk), .reset_ni(reset_ni), .capture_i(capture_i), .continuous_i(continuous_i),
        .vospi_start_o(vospi_start_o), .vospi_valid_i(vospi_valid_i), .vospi_data_i(vospi_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o), .line_o(line_o),
        .frame_done_o(frame_done_o), .busy_o(busy_o), .timeout_o(timeout_o),
        .frame_count_o(frame_count_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (vospi_start_o) starts++;
        if (frame_done_o) dones++;
    end

    typedef struct {
        logic        cap, cont, valid;
        logic [7:0]  data;
        logic        start, wr_en;
        logic [3:0]  addr;
        logic [7:0]  wdata;
        logic [1:0]  line;
        logic        done, busy;
        logic [15:0] count;
    } vec_t;

    vec_t vecs[17];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cap, input logic cont, input logic valid, input logic [7:0] data);
        capture_i = cap;
        continuous_i = cont;
        vospi_valid_i = valid;
        vospi_data_i = data;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 32'(vospi_start_o), 0);
        chk({tag, "_wr_en"}, 32'(wr_en_o), 0);
        chk({tag, "_addr"}, 32'(wr_addr_o), 0);
        chk({tag, "_wdata"}, 32'(wr_data_o), 0);
        chk({tag, "_line"}, 32'(line_o), 0);
        chk({tag, "_done"}, 32'(frame_done_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
        chk({tag, "_timeout"}, 32'(timeout_o), 0);
        chk({tag, "_count"}, 32'(frame_count_o), 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b1, 16'd0};
        for (int i = 0; i < 12; i++)
            vecs[2+i] = '{1'b0, 1'b0, 1'b1, 8'(i), 1'b0, 1'b1, 4'(i), 8'(i), 2'(i / 4),
                          i == 11, i != 11, 16'(i == 11)};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd1};
        vecs[16] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 4'd0, 8'h00, 2'd0, 1'b0, 1'b0, 16'd1};

        repeat (3) tick();
        chk_all_zero("reset");
        reset_ni = 1'b1;
        repeat (2) tick();

        // single frame, then strobes while idle
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].cap, vecs[i].cont, vecs[i].valid, vecs[i].data);
            tick();
            chk($sformatf("v%0d_start", i), 32'(vospi_start_o), 32'(vecs[i].start));
            chk($sformatf("v%0d_wr_en", i), 32'(wr_en_o), 32'(vecs[i].wr_en));
            chk($sformatf("v%0d_done", i), 32'(frame_done_o), 32'(vecs[i].done));
            chk($sformatf("v%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
            chk($sformatf("v%0d_count", i), 32'(frame_count_o), 32'(vecs[i].count));
            if (vecs[i].wr_en) begin
                chk($sformatf("v%0d_addr", i), 32'(wr_addr_o), 32'(vecs[i].addr));
                chk($sformatf("v%0d_wdata", i), 32'(wr_data_o), 32'(vecs[i].wdata));
                chk($sformatf("v%0d_line", i), 32'(line_o), 32'(vecs[i].line));
            end
        end

        // continuous mode: two frames back to back from a single start
        s0 = starts; d0 = dones; busy_ok = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
        for (int i = 0; i < 24; i++) begin
            drive(1'b0, 1'b1, 1'b1, 8'(8'h10 + i)); tick();
            if (!busy_o) busy_ok = 1'b0;
            if (i == 11) chk("cont_addr_11", 32'(wr_addr_o), 11);
            if (i == 12) chk("cont_addr_wrap", 32'(wr_addr_o), 0);
        end
        drive(1'b0, 1'b1, 1'b0, 8'h00); tick();
        chk("cont_busy_stays", 32'(busy_ok && busy_o), 1);
        chk("cont_starts", 32'(starts - s0), 1);
        chk("cont_dones", 32'(dones - d0), 2);
        chk("cont_count", 32'(frame_count_o), 3);

        // async reset mid-frame after 7 bytes
        d0 = dones;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(8'h40 + i)); tick();
        end
        chk("pre_reset_addr", 32'(wr_addr_o), 6);
        reset_ni = 1'b0;
        #1;
        chk_all_zero("async_reset");
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) tick();
        chk("reset_no_done", 32'(dones - d0), 0);
        reset_ni = 1'b1;
        repeat (3) tick();
        chk("post_reset_idle", 32'(busy_o), 0);

        // restart from address 0; capture_i pulses during CAPTURE are ignored
        s0 = starts;
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        chk("restart_start", 32'(vospi_start_o), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int i = 0; i < 12; i++) begin
            drive(i >= 3 && i <= 5, 1'b0, 1'b1, 8'(8'h80 + i)); tick();
            chk($sformatf("re_addr%0d", i), 32'(wr_addr_o), 32'(i));
            chk($sformatf("re_data%0d", i), 32'(wr_data_o), 32'(8'h80 + i));
        end
        chk("re_done", 32'(frame_done_o), 1);
        chk("re_count", 32'(frame_count_o), 1);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("re_starts", 32'(starts - s0), 1);
        chk("re_idle", 32'(busy_o), 0);

`ifdef VOSPI_FRAME_CTRL_TIMEOUT_EN
        d0 = dones;
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i)); tick();
        end
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (19) tick();
        chk("to_before_expiry", 32'(timeout_o), 0);
        tick();
        chk("to_flag", 32'(timeout_o), 1);
        chk("to_abort_busy", 32'(busy_o), 1);
        tick();
        chk("to_idle", 32'(busy_o), 0);
        chk("to_no_done", 32'(dones - d0), 0);
        chk("to_count", 32'(frame_count_o), 1);
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        chk("to_cleared", 32'(timeout_o), 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b1, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (19) tick();
        drive(1'b0, 1'b0, 1'b1, 8'h01); tick();
        chk("to_edge_wr", 32'(wr_en_o), 1);
        chk("to_edge_addr", 32'(wr_addr_o), 1);
        chk("to_edge_flag", 32'(timeout_o), 0);
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("to_edge_busy", 32'(busy_o), 1);
        for (int i = 2; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i)); tick();
        end
        chk("to_edge_done", 32'(frame_done_o), 1);
        chk("to_edge_count", 32'(frame_count_o), 2);
`else
        drive(1'b1, 1'b0, 1'b0, 8'h00); tick();
        drive(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (101) tick();
        chk("nowd_timeout", 32'(timeout_o), 0);
        chk("nowd_busy", 32'(busy_o), 1);
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i)); tick();
        end
        chk("nowd_done", 32'(frame_done_o), 1);
        chk("nowd_count", 32'(frame_count_o), 2);
`endif
        drive(1'b0, 1'b0, 1'b0, 8'h00); tick();
        chk("final_idle", 32'(busy_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
